// File: rtl/mul_unit.sv
// Iterative radix-2 shift-add HI/LO multiply unit (MUL, MADD, MADDU, MFHI, MFLO).
// Optional MUL_EARLY_TERM_EN: leave MULT as soon as the remaining multiplier bits are zero.
module mul_unit #(
  parameter int          WIDTH     = 32,
  parameter logic [2:0]  MUL_MADD  = 3'b000,
  parameter logic [2:0]  MUL_MADDU = 3'b001,
  parameter logic [2:0]  MUL_MUL   = 3'b010,
  parameter logic [2:0]  MUL_MFLO  = 3'b100,
  parameter logic [2:0]  MUL_MFHI  = 3'b101
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid,
  input  logic [2:0]       mul_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             stall,
  output logic             done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, MULT, ACC} state_t;

  state_t               state, state_next;
  logic [2*WIDTH-1:0]   product, mcand, signed_p, acc_sum;
  logic [WIDTH-1:0]     mplier, a_mag, b_mag;
  logic [CW-1:0]        count;
  logic [2:0]           op;
  logic                 neg, start, signed_op, mult_last;

  assign start     = (state == IDLE) && valid &&
                     ((mul_op == MUL_MADD) || (mul_op == MUL_MADDU) || (mul_op == MUL_MUL));
  assign signed_op = (mul_op != MUL_MADDU);
  assign a_mag     = (signed_op && a[WIDTH-1]) ? -a : a;
  assign b_mag     = (signed_op && b[WIDTH-1]) ? -b : b;
  assign signed_p  = neg ? -product : product;
  assign acc_sum   = {hi, lo} + signed_p;

`ifdef MUL_EARLY_TERM_EN
  // Bits still to be consumed after this edge's shift are mplier[WIDTH-1:1].
  assign mult_last = (mplier[WIDTH-1:1] == '0) || (count == CW'(WIDTH-1));
`else
  assign mult_last = (count == CW'(WIDTH-1));
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = MULT;
      MULT:    if (mult_last) state_next = ACC;
      ACC:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy   = (state != IDLE);
    stall  = busy && valid;
    result = (mul_op == MUL_MFHI) ? hi : lo;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hi      <= '0;
      lo      <= '0;
      done    <= 1'b0;
      product <= '0;
      mcand   <= '0;
      mplier  <= '0;
      count   <= '0;
      op      <= '0;
      neg     <= 1'b0;
    end else begin
      done <= (state == ACC);
      case (state)
        IDLE: if (start) begin
          op      <= mul_op;
          mcand   <= {{WIDTH{1'b0}}, a_mag};
          mplier  <= b_mag;
          neg     <= signed_op && (a[WIDTH-1] ^ b[WIDTH-1]);
          product <= '0;
          count   <= '0;
        end
        MULT: begin
          if (mplier[0]) product <= product + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          count  <= count + 1'b1;
        end
        ACC: begin
          if (op == MUL_MUL) {hi, lo} <= signed_p;
          else               {hi, lo} <= acc_sum;
        end
        default: ;
      endcase
    end
  end

endmodule
